// File: rtl/count_step_decoder_pkg.sv
// count_pkg
// Shared types for the count step decoder:
//   state_t : lock FSM states (IDLE, TRACK, LOCK_UP, LOCK_DWN)
//   step_t  : class of the last observed step (HOLD, UP, DWN, JUMP)
//   RUN_W   : width of the consecutive-step run counter
package count_pkg;

   localparam int RUN_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRACK    = 2'd1,
      LOCK_UP  = 2'd2,
      LOCK_DWN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      UP   = 2'd1,
      DWN  = 2'd2,
      JUMP = 2'd3
   } step_t;

endpackage

// File: rtl/count_step_decoder_if.sv
// count_step_decoder_if
// Bundles the observed counter bus and the decoder status outputs.
//   master : drives count_in, valid_in, clr_stats; reads decoder outputs
//   slave  : the decoder side (reads samples, drives pulses/state/statistics)
interface count_step_decoder_if #(
   parameter int SIZE  = 2,
   parameter int CNT_W = 8
) ();
   logic [SIZE-1:0]  count_in;
   logic             valid_in;
   logic             clr_stats;
   logic             step_up;
   logic             step_dwn;
   logic             jump;
   logic             hold;
   logic             dir;
   logic             locked;
   logic [CNT_W-1:0] up_cnt;
   logic [CNT_W-1:0] dwn_cnt;
   logic [CNT_W-1:0] jump_cnt;

   modport master (
      output count_in, valid_in, clr_stats,
      input  step_up, step_dwn, jump, hold, dir, locked, up_cnt, dwn_cnt, jump_cnt
   );

   modport slave (
      input  count_in, valid_in, clr_stats,
      output step_up, step_dwn, jump, hold, dir, locked, up_cnt, dwn_cnt, jump_cnt
   );
endinterface

// File: rtl/count_step_classify.sv
// count_step_classify
// Combinational step classifier: diff = (count_in - prev) mod 2^SIZE.
//   count_in : current sample
//   prev     : previous valid sample
//   cls      : HOLD (diff 0), UP (diff 1), DWN (diff all-ones), JUMP (other)
module count_step_classify
   import count_pkg::*;
#(
   parameter int SIZE = 2
) (
   input  logic [SIZE-1:0] count_in,
   input  logic [SIZE-1:0] prev,
   output step_t           cls
);
   localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

   logic [SIZE-1:0] diff_s;

   // Modular difference; the natural wrap makes 3->0 an up step and 0->3 a down step.
   always_comb begin
      diff_s = count_in - prev;
      if (diff_s == {SIZE{1'b0}}) begin
         cls = HOLD;
      end else if (diff_s == ONE) begin
         cls = UP;
      end else if (diff_s == {SIZE{1'b1}}) begin
         cls = DWN;
      end else begin
         cls = JUMP;
      end
   end
endmodule

// File: rtl/count_step_decoder.sv
// count_step_decoder
// Observes an up/down/load counter, decodes each valid step, tracks a
// direction-lock FSM and keeps saturating per-event statistics.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; dominates clr_stats and valid_in
//   bus   : slave side of count_step_decoder_if (samples in, status out)
// All outputs are registered (latency 1 from the sampling edge).
module count_step_decoder
   import count_pkg::*;
#(
   parameter int SIZE   = 2,
   parameter int LOCK_N = 3,
   parameter int CNT_W  = 8
) (
   input logic                  clk,
   input logic                  reset,
   count_step_decoder_if.slave  bus
);
   localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);

   step_t            cls_s;
   state_t           state_r, state_n;
   logic [RUN_W-1:0] run_r, run_n;
   logic             run_dir_r, run_dir_n;
   logic [SIZE-1:0]  prev_r;
   logic             pulse_en_s;
   logic             match_s;
   logic             step_up_r, step_dwn_r, jump_r, hold_r, dir_r, locked_r;
   logic [CNT_W-1:0] up_cnt_r, dwn_cnt_r, jump_cnt_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   count_step_classify #(.SIZE(SIZE)) u_classify (
      .count_in (bus.count_in),
      .prev     (prev_r),
      .cls      (cls_s)
   );

   // The first sample after reset only seeds prev; it produces no pulse or statistic.
   assign pulse_en_s = bus.valid_in && (state_r != IDLE);
   assign match_s    = ((cls_s == UP) && run_dir_r) || ((cls_s == DWN) && !run_dir_r);

   // Next-state, run length and run direction for a valid sample.
   always_comb begin
      state_n   = state_r;
      run_n     = run_r;
      run_dir_n = run_dir_r;
      case (state_r)
         IDLE: begin
            state_n = TRACK;
            run_n   = {RUN_W{1'b0}};
         end
         TRACK: begin
            case (cls_s)
               UP, DWN: begin
                  // A fresh run (run = 0) accepts either direction.
                  if ((run_r == {RUN_W{1'b0}}) || match_s) begin
                     run_n = run_r + RUN_ONE;
                  end else begin
                     run_n = RUN_ONE;
                  end
                  run_dir_n = (cls_s == UP);
                  if (run_n >= RUN_LOCK) begin
                     state_n = (cls_s == UP) ? LOCK_UP : LOCK_DWN;
                  end else begin
                     state_n = TRACK;
                  end
               end
               JUMP:    run_n = {RUN_W{1'b0}};
               HOLD:    run_n = run_r;
               default: run_n = run_r;
            endcase
         end
         LOCK_UP, LOCK_DWN: begin
            if (cls_s == JUMP) begin
               state_n = TRACK;
               run_n   = {RUN_W{1'b0}};
            end else if ((cls_s == HOLD) || match_s) begin
               state_n = state_r;
            end else begin
               state_n   = TRACK;
               run_n     = RUN_ONE;
               run_dir_n = (cls_s == UP);
            end
         end
         default: begin
            state_n = IDLE;
            run_n   = {RUN_W{1'b0}};
         end
      endcase
   end

   // State, prev sample and registered pulse/lock outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         run_r      <= {RUN_W{1'b0}};
         run_dir_r  <= 1'b0;
         prev_r     <= {SIZE{1'b0}};
         step_up_r  <= 1'b0;
         step_dwn_r <= 1'b0;
         jump_r     <= 1'b0;
         hold_r     <= 1'b0;
         locked_r   <= 1'b0;
         dir_r      <= 1'b0;
      end else if (bus.valid_in) begin
         state_r    <= state_n;
         run_r      <= run_n;
         run_dir_r  <= run_dir_n;
         prev_r     <= bus.count_in;
         step_up_r  <= pulse_en_s && (cls_s == UP);
         step_dwn_r <= pulse_en_s && (cls_s == DWN);
         jump_r     <= pulse_en_s && (cls_s == JUMP);
         hold_r     <= pulse_en_s && (cls_s == HOLD);
         locked_r   <= (state_n == LOCK_UP) || (state_n == LOCK_DWN);
         dir_r      <= (state_n == LOCK_UP);
      end else begin
         step_up_r  <= 1'b0;
         step_dwn_r <= 1'b0;
         jump_r     <= 1'b0;
         hold_r     <= 1'b0;
      end
   end

   // Saturating event statistics; clr_stats beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || bus.clr_stats) begin
         up_cnt_r   <= {CNT_W{1'b0}};
         dwn_cnt_r  <= {CNT_W{1'b0}};
         jump_cnt_r <= {CNT_W{1'b0}};
      end else if (pulse_en_s) begin
         if (cls_s == UP)   up_cnt_r   <= sat_inc(up_cnt_r);
         else               up_cnt_r   <= up_cnt_r;
         if (cls_s == DWN)  dwn_cnt_r  <= sat_inc(dwn_cnt_r);
         else               dwn_cnt_r  <= dwn_cnt_r;
         if (cls_s == JUMP) jump_cnt_r <= sat_inc(jump_cnt_r);
         else               jump_cnt_r <= jump_cnt_r;
      end else begin
         up_cnt_r   <= up_cnt_r;
         dwn_cnt_r  <= dwn_cnt_r;
         jump_cnt_r <= jump_cnt_r;
      end
   end

   assign bus.step_up  = step_up_r;
   assign bus.step_dwn = step_dwn_r;
   assign bus.jump     = jump_r;
   assign bus.hold     = hold_r;
   assign bus.locked   = locked_r;
   assign bus.dir      = dir_r;
   assign bus.up_cnt   = up_cnt_r;
   assign bus.dwn_cnt  = dwn_cnt_r;
   assign bus.jump_cnt = jump_cnt_r;
endmodule

// File: tb/tb_count_step_decoder.sv
// tb_count_step_decoder
// Directed bench: one main decoder (CNT_W=8) and one with CNT_W=2 for
// saturation, both fed the same sample stream.
// Flags vector order: {step_up, step_dwn, jump, hold, locked, dir}.
module tb_count_step_decoder;
   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] count_d;
   logic       valid_d;
   logic       clr_d;
   int         total = 0;
   int         bad   = 0;

   count_step_decoder_if #(.SIZE(2), .CNT_W(8)) m_if ();
   count_step_decoder_if #(.SIZE(2), .CNT_W(2)) s_if ();

   assign m_if.count_in  = count_d;
   assign m_if.valid_in  = valid_d;
   assign m_if.clr_stats = clr_d;
   assign s_if.count_in  = count_d;
   assign s_if.valid_in  = valid_d;
   assign s_if.clr_stats = clr_d;

   count_step_decoder #(.SIZE(2), .LOCK_N(3), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (m_if.slave)
   );

   count_step_decoder #(.SIZE(2), .LOCK_N(3), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (s_if.slave)
   );

   wire [5:0] flags = {m_if.step_up, m_if.step_dwn, m_if.jump, m_if.hold, m_if.locked, m_if.dir};

   always #5 clk = ~clk;

   task automatic sample(input logic [1:0] v, input logic clr);
      count_d = v;
      valid_d = 1'b1;
      clr_d   = clr;
      @(posedge clk);
      #1;
      valid_d = 1'b0;
      clr_d   = 1'b0;
   endtask

   task automatic idle(input logic [1:0] v, input logic clr);
      count_d = v;
      valid_d = 1'b0;
      clr_d   = clr;
      @(posedge clk);
      #1;
      clr_d   = 1'b0;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      valid_d = 1'b1;
      clr_d   = 1'b0;
      count_d = 2'd2;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      valid_d = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({flags, m_if.up_cnt, m_if.dwn_cnt, m_if.jump_cnt} !== 30'd0) begin
         $display("FAIL reset got=%b/%0d/%0d/%0d exp=0", flags, m_if.up_cnt, m_if.dwn_cnt, m_if.jump_cnt);
         bad++;
      end
   endtask

   task automatic test_up_lock();
      logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [5:0] exp [4] = '{6'b000000, 6'b100000, 6'b100000, 6'b100011};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sample(seq[i], 1'b0);
         total++;
         if (flags !== exp[i]) begin
            $display("FAIL up_lock[%0d] got=%b exp=%b", i, flags, exp[i]);
            bad++;
         end
      end
      total++;
      if (m_if.up_cnt !== 8'd3) begin
         $display("FAIL up_lock_cnt got=%0d exp=3", m_if.up_cnt);
         bad++;
      end
   endtask

   // Continues from the locked-up state left by test_up_lock (prev = 3).
   task automatic test_wrap();
      logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2};
      logic [5:0] exp [5] = '{6'b100011, 6'b100011, 6'b010000, 6'b010000, 6'b010010};
      for (int i = 0; i < 5; i++) begin
         sample(seq[i], 1'b0);
         total++;
         if (flags !== exp[i]) begin
            $display("FAIL wrap[%0d] got=%b exp=%b", i, flags, exp[i]);
            bad++;
         end
      end
      total++;
      if ({m_if.up_cnt, m_if.dwn_cnt} !== {8'd5, 8'd3}) begin
         $display("FAIL wrap_cnt got=%0d/%0d exp=5/3", m_if.up_cnt, m_if.dwn_cnt);
         bad++;
      end
   endtask

   task automatic test_down_lock();
      logic [1:0] seq [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
      logic [5:0] exp [4] = '{6'b000000, 6'b010000, 6'b010000, 6'b010010};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sample(seq[i], 1'b0);
         total++;
         if (flags !== exp[i]) begin
            $display("FAIL down_lock[%0d] got=%b exp=%b", i, flags, exp[i]);
            bad++;
         end
      end
      total++;
      if ({m_if.up_cnt, m_if.dwn_cnt} !== {8'd0, 8'd3}) begin
         $display("FAIL down_lock_cnt got=%0d/%0d exp=0/3", m_if.up_cnt, m_if.dwn_cnt);
         bad++;
      end
   endtask

   task automatic test_jump();
      logic [1:0] seq [9]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0};
      logic [5:0] exp [9]  = '{6'b000000, 6'b100000, 6'b100000, 6'b100011, 6'b100011,
                               6'b100011, 6'b001000, 6'b000100, 6'b100000};
      logic [7:0] ujc [9]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5, 8'd6};
      logic [7:0] jc  [9]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         sample(seq[i], 1'b0);
         total++;
         if ({flags, m_if.up_cnt, m_if.jump_cnt, m_if.dwn_cnt} !== {exp[i], ujc[i], jc[i], 8'd0}) begin
            $display("FAIL jump[%0d] got=%b/%0d/%0d/%0d exp=%b/%0d/%0d/0", i, flags, m_if.up_cnt,
                     m_if.jump_cnt, m_if.dwn_cnt, exp[i], ujc[i], jc[i]);
            bad++;
         end
      end
   endtask

   task automatic test_gap_and_reset();
      do_reset();
      sample(2'd0, 1'b0);
      sample(2'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         idle(2'd3, 1'b0);
         total++;
         if (flags !== 6'b000000) begin
            $display("FAIL gap[%0d] got=%b exp=000000", i, flags);
            bad++;
         end
      end
      // prev must still be 1, so 2 is an up step and 3 completes the lock.
      sample(2'd2, 1'b0);
      total++;
      if (flags !== 6'b100000) begin
         $display("FAIL gap_resume got=%b exp=100000", flags);
         bad++;
      end
      sample(2'd3, 1'b0);
      total++;
      if ({flags, m_if.up_cnt} !== {6'b100011, 8'd3}) begin
         $display("FAIL gap_lock got=%b/%0d exp=100011/3", flags, m_if.up_cnt);
         bad++;
      end
      // Mid-lock reset with valid and clear asserted: reset wins.
      reset   = 1'b1;
      valid_d = 1'b1;
      clr_d   = 1'b1;
      count_d = 2'd0;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      valid_d = 1'b0;
      clr_d   = 1'b0;
      total++;
      if ({flags, m_if.up_cnt} !== 14'd0) begin
         $display("FAIL mid_reset got=%b/%0d exp=000000/0", flags, m_if.up_cnt);
         bad++;
      end
      sample(2'd1, 1'b0);
      total++;
      if ({flags, m_if.up_cnt} !== 14'd0) begin
         $display("FAIL post_reset_first got=%b/%0d exp=000000/0", flags, m_if.up_cnt);
         bad++;
      end
      sample(2'd2, 1'b0);
      total++;
      if ({flags, m_if.up_cnt} !== {6'b100000, 8'd1}) begin
         $display("FAIL post_reset_step got=%b/%0d exp=100000/1", flags, m_if.up_cnt);
         bad++;
      end
   endtask

   task automatic test_saturation();
      logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [1:0] exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         sample(seq[i], 1'b0);
         total++;
         if (s_if.up_cnt !== exp[i]) begin
            $display("FAIL sat[%0d] got=%0d exp=%0d", i, s_if.up_cnt, exp[i]);
            bad++;
         end
      end
      // Clear on the same cycle as a sixth up step: counter reads 0, pulse still fires.
      sample(2'd2, 1'b1);
      total++;
      if ({s_if.up_cnt, m_if.up_cnt, flags} !== {2'd0, 8'd0, 6'b100011}) begin
         $display("FAIL sat_clr got=%0d/%0d/%b exp=0/0/100011", s_if.up_cnt, m_if.up_cnt, flags);
         bad++;
      end
      sample(2'd3, 1'b0);
      total++;
      if ({s_if.up_cnt, m_if.up_cnt} !== {2'd1, 8'd1}) begin
         $display("FAIL sat_after_clr got=%0d/%0d exp=1/1", s_if.up_cnt, m_if.up_cnt);
         bad++;
      end
      // Clear without a valid sample; lock state is held.
      idle(2'd0, 1'b1);
      total++;
      if ({m_if.up_cnt, flags} !== {8'd0, 6'b000011}) begin
         $display("FAIL clr_idle got=%0d/%b exp=0/000011", m_if.up_cnt, flags);
         bad++;
      end
   endtask

   initial begin
      reset   = 1'b1;
      valid_d = 1'b0;
      clr_d   = 1'b0;
      count_d = 2'd0;
      test_reset();
      test_up_lock();
      test_wrap();
      test_down_lock();
      test_jump();
      test_gap_and_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/count_step_decoder.md
# count_step_decoder

Receive-side companion to the up/down/load counter: samples a counter's output value each valid cycle and decodes which command the counter executed (hold, count up, count down, or load/reset jump). It tracks a lock state machine that declares a stable count direction after LOCK_N consecutive same-direction steps, and keeps saturating per-event statistics. It sits beside the counter in the verification and status path, consuming the counter's `out` bus.

## Interface
- SIZE, 2, width of observed count value; must be ≥ 2.
- LOCK_N, 3, consecutive same-direction steps required to lock; range 1..255.
- CNT_W, 8, width of each statistics counter.
- clk  input  1  rising-edge clock.
- reset  input  1  reset is synchronous and active-high.
- count_in  input  SIZE  observed counter value.
- valid_in  input  1  count_in is a valid sample this cycle.
- clr_stats  input  1  synchronous clear of up_cnt/dwn_cnt/jump_cnt.
- step_up  output  1  one-cycle pulse: last sample was previous + 1 (mod 2^SIZE).
- step_dwn  output  1  one-cycle pulse: last sample was previous − 1 (mod 2^SIZE).
- jump  output  1  one-cycle pulse: any other nonzero difference (load/reset).
- hold  output  1  one-cycle pulse: sample equal to previous.
- dir  output  1  locked direction, 1 = up, 0 = down; valid only while locked.
- locked  output  1  FSM in LOCK_UP or LOCK_DWN.
- up_cnt, dwn_cnt, jump_cnt  output  CNT_W each  saturating event counters.

## Operation
- Classification: diff = (count_in − prev) mod 2^SIZE; diff = 0 → HOLD; diff = 1 → UP; diff = 2^SIZE−1 → DWN; else JUMP. Wrap-around is a step: 3→0 is UP, 0→3 is DWN (SIZE=2).
- prev updates to count_in on every valid sample.
- States: IDLE (no prior sample), TRACK, LOCK_UP, LOCK_DWN. run counter (8 bits) and run_dir register.
- IDLE: first valid sample stores prev, goes TRACK, run = 0; no pulse, no statistics.
- TRACK: UP/DWN matching run_dir (or run = 0) → run+1, run_dir set; mismatching step → run = 1, run_dir flipped; JUMP → run = 0; HOLD → unchanged. When run reaches LOCK_N → LOCK_UP/LOCK_DWN per run_dir.
- LOCK_x: same-direction step or HOLD → stay; opposite step → TRACK, run = 1, new run_dir; JUMP → TRACK, run = 0.
- LOCK_N = 1: first step from TRACK locks immediately.
- Statistics: UP, DWN, JUMP increment the matching counter; saturate at 2^CNT_W−1 and stay. HOLD counts nothing.
- clr_stats the same cycle as an increment: clear wins, counter = 0.
- valid_in low: no pulses, prev/state/run/counters held.

## Timing
- All outputs registered; pulses and state change appear the cycle after the sampling edge (latency 1).
- Pulses are exactly one cycle; exactly one of step_up/step_dwn/jump/hold is high after each valid sample from TRACK/LOCK states, none otherwise.
- locked and dir update the same cycle as the pulse causing the transition.
- Reset: all outputs 0, state IDLE, prev = 0, run = 0; reset asserted mid-stream discards prev, so the next valid sample is classified as a first sample (no pulse).
- reset dominates clr_stats and valid_in.

## Structure
- Shared package count_pkg: state enum (IDLE, TRACK, LOCK_UP, LOCK_DWN) and step class enum (HOLD, UP, DWN, JUMP).
- One combinational sub-module count_step_classify (SIZE-parameterised; count_in, prev → class); FSM, run counter and statistics in the top.

## Test plan
- SIZE=2, LOCK_N=3: after reset, valid samples 0,1,2,3 → no pulse on first, then three step_up pulses; locked=1, dir=1 the cycle after sample 3; up_cnt=3.
- Wrap: locked up, samples 3,0,1 → step_up on each, stays locked; then 0 → step_dwn, locked=0, run=1.
- Down lock: samples 2,1,0,3 → three step_dwn, locked=1, dir=0; dwn_cnt=3.
- Jump: locked up at 1, sample 3 → jump pulse, locked=0, jump_cnt+1; sample 3 again → hold, no counter change.
- Saturation/clear: CNT_W=2, five up steps → up_cnt=3 held; clr_stats with sixth step → up_cnt=0.
- valid gaps and reset: valid_in low 4 cycles mid-stream → no pulses, state held; reset mid-lock → all outputs 0, next sample produces no pulse.
